// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath types plus fetch queue state and entry definitions
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_datbus;
  typedef enum logic [1:0] {FQ_IDLE, FQ_REQ, FQ_DISCARD} fq_state_t;
  typedef struct packed {
    lc3b_word pc;
    lc3b_word instr;
  } fq_entry_t;
  function automatic lc3b_word line_word(lc3b_datbus line, logic [2:0] idx);
    return line[{idx, 4'b0000} +: 16];
  endfunction
endpackage

// File: rtl/instr_ring.sv
// instr_ring: circular instruction buffer accepting up to two pushes and one pop per cycle, with clear
module instr_ring
  import lc3b_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [1:0]    push_n,
  input  fq_entry_t     push0,
  input  fq_entry_t     push1,
  input  logic          pop,
  output logic [CW-1:0] count,
  output fq_entry_t     head
);
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, tail1;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     mem_d [DEPTH];

  assign pop_ok = pop && count_q != '0;
  assign tail1  = tail_q + AW'(1);
  assign count  = count_q;
  assign head   = mem_q[head_q];

  // slot writes, pointer advance and occupancy; clear empties the ring and drops same-cycle traffic
  always_comb begin
    mem_d = mem_q;
    if (!clear && push_n != 2'd0) mem_d[tail_q] = push0;
    if (!clear && push_n == 2'd2) mem_d[tail1] = push1;
    head_d  = clear ? '0 : head_q + AW'(pop_ok);
    tail_d  = clear ? '0 : tail_q + AW'(push_n);
    count_d = clear ? '0 : count_q + CW'(push_n) - CW'(pop_ok);
  end

  // ring state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: icache fetch FSM and PC sequencing that fills an instr_ring for decode
module fetch_queue
  import lc3b_types::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          FILL     = 1,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  output logic [15:0]  icache_addr,
  output logic         icache_read,
  input  logic         icache_resp,
  input  logic [127:0] icache_rdata,
  input  logic         redirect,
  input  logic [15:0]  redirect_pc,
  input  logic         deq_ready,
  output logic         deq_valid,
  output logic [15:0]  deq_instr,
  output logic [15:0]  deq_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FIT_MAX = CW'(DEPTH - FILL);

  fq_state_t     state_q, state_d;
  lc3b_word      fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic [CW-1:0] count, count_n;
  logic [2:0]    idx;
  logic [1:0]    push_n;
  logic          accept, pop;
  fq_entry_t     head, push0, push1;

  assign idx     = fetch_pc_q[3:1];
  assign accept  = state_q == FQ_REQ && icache_resp && !redirect;
  assign push_n  = !accept ? 2'd0 : (FILL == 2 && idx != 3'd7) ? 2'd2 : 2'd1;
  assign pop     = deq_valid && deq_ready && !redirect;
  assign count_n = count + CW'(push_n) - CW'(pop);
  assign push0   = '{pc: fetch_pc_q + 16'd2, instr: line_word(icache_rdata, idx)};
  assign push1   = '{pc: fetch_pc_q + 16'd4, instr: line_word(icache_rdata, idx + 3'd1)};

  instr_ring #(.DEPTH(DEPTH)) u_ring (
    .clk    (clk),
    .reset  (reset),
    .clear  (redirect),
    .push_n (push_n),
    .push0  (push0),
    .push1  (push1),
    .pop    (pop),
    .count  (count),
    .head   (head)
  );

  assign deq_valid   = count != '0;
  assign deq_instr   = head.instr;
  assign deq_pc      = head.pc;
  assign icache_read = state_q != FQ_IDLE;
  assign icache_addr = state_q == FQ_DISCARD ? addr_q : fetch_pc_q;

  // next state, fetch pc, and the in-flight address kept while a stale response drains
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & 16'hFFFE;
      if (state_q == FQ_REQ && !icache_resp) begin
        state_d = FQ_DISCARD;
        addr_d  = fetch_pc_q;
      end else if (state_q == FQ_DISCARD && icache_resp) state_d = FQ_REQ;
    end else if (state_q == FQ_IDLE) state_d = count <= FIT_MAX ? FQ_REQ : FQ_IDLE;
    else if (icache_resp) begin
      state_d    = state_q == FQ_DISCARD || count_n <= FIT_MAX ? FQ_REQ : FQ_IDLE;
      fetch_pc_d = fetch_pc_q + {13'd0, push_n, 1'b0};
    end
  end

  // fetch state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FQ_IDLE;
      fetch_pc_q <= RESET_PC & 16'hFFFE;
      addr_q     <= RESET_PC & 16'hFFFE;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checking of two fetch_queue configurations against a queue model
module tb_fetch_queue;
  logic         clk = 0;
  logic         reset = 1, redirect = 0, deq_ready = 0;
  logic [15:0]  redirect_pc = 0;
  logic         resp [2] = '{0, 0};
  logic [127:0] rdata [2];
  logic         rd [2], dv [2];
  logic [15:0]  addr [2], dinstr [2], dpc [2];
  int           lat = 1;
  int           wc [2] = '{0, 0};
  int           fills [2] = '{1, 2};
  logic [15:0]  rpcs [2] = '{16'h0000, 16'h1230};
  int           n_cmp = 0, n_bad = 0;

  logic [31:0]  mq [2][$];
  logic [15:0]  fpc [2], pend [2];
  bit           busy [2], stale [2];
  bit           live = 0;
  int           sz, nw, n0;
  logic [15:0]  alog [2][$], plog [2][$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .FILL(1), .RESET_PC(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .icache_addr(addr[0]), .icache_read(rd[0]),
    .icache_resp(resp[0]), .icache_rdata(rdata[0]), .redirect(redirect),
    .redirect_pc(redirect_pc), .deq_ready(deq_ready), .deq_valid(dv[0]),
    .deq_instr(dinstr[0]), .deq_pc(dpc[0]));

  fetch_queue #(.DEPTH(4), .FILL(2), .RESET_PC(16'h1230)) dut1 (
    .clk(clk), .reset(reset), .icache_addr(addr[1]), .icache_read(rd[1]),
    .icache_resp(resp[1]), .icache_rdata(rdata[1]), .redirect(redirect),
    .redirect_pc(redirect_pc), .deq_ready(deq_ready), .deq_valid(dv[1]),
    .deq_instr(dinstr[1]), .deq_pc(dpc[1]));

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] qget(logic [15:0] q [$], int i);
    return i < q.size() ? q[i] : 16'hxxxx;
  endfunction

  // icache: answers a held read once it has waited more than lat cycles
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      if (reset) wc[k] = 0;
      else wc[k] = resp[k] ? (rd[k] ? 1 : 0) : (rd[k] ? wc[k] + 1 : 0);
      resp[k]  = !reset && rd[k] && wc[k] > lat;
      rdata[k] = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // reference model: instruction queue, fetch pc and outstanding-request bookkeeping
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mq[k].delete();
        fpc[k] = rpcs[k];
        busy[k] = 0;
        stale[k] = 0;
      end else if (redirect) begin
        mq[k].delete();
        if (busy[k] && resp[k]) stale[k] = 0;
        else if (busy[k] && !stale[k]) begin
          stale[k] = 1;
          pend[k] = fpc[k];
        end
        fpc[k] = redirect_pc & 16'hFFFE;
      end else begin
        sz = mq[k].size();
        if (deq_ready && sz > 0) void'(mq[k].pop_front());
        if (busy[k] && resp[k]) begin
          if (stale[k]) stale[k] = 0;
          else begin
            nw = (fills[k] == 2 && fpc[k][3:1] != 3'd7) ? 2 : 1;
            for (int i = 0; i < nw; i++) begin
              mq[k].push_back({fpc[k] + 16'd2, rdata[k][16*fpc[k][3:1] +: 16]});
              fpc[k] = fpc[k] + 16'd2;
            end
            busy[k] = 4 - mq[k].size() >= fills[k];
          end
        end else if (!busy[k] && 4 - sz >= fills[k]) busy[k] = 1;
      end
    end
    if (reset) live = 1;
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("icache_read%0d", k), {31'd0, rd[k]}, {31'd0, busy[k]});
        chk($sformatf("deq_valid%0d", k), {31'd0, dv[k]}, {31'd0, mq[k].size() != 0});
        if (busy[k]) chk($sformatf("icache_addr%0d", k), {16'd0, addr[k]}, {16'd0, stale[k] ? pend[k] : fpc[k]});
        if (mq[k].size() != 0) begin
          chk($sformatf("deq_instr%0d", k), {16'd0, dinstr[k]}, {16'd0, mq[k][0][15:0]});
          chk($sformatf("deq_pc%0d", k), {16'd0, dpc[k]}, {16'd0, mq[k][0][31:16]});
        end
      end
    end
  end

  // log of accepted request addresses and dequeued pcs for directed checks
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (rd[k] && resp[k]) alog[k].push_back(addr[k]);
        if (dv[k] && deq_ready) plog[k].push_back(dpc[k]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      alog[k].delete();
      plog[k].delete();
    end
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(2);
    reset = 0;
    clear_logs();
  endtask

  initial begin
    cyc(3);
    @(negedge clk);
    chk("rst_read", {31'd0, rd[0]}, 0);
    chk("rst_valid", {31'd0, dv[0]}, 0);
    chk("rst_addr0", {16'd0, addr[0]}, 32'h0000);
    chk("rst_addr1", {16'd0, addr[1]}, 32'h1230);
    chk("rst_pc", {16'd0, dpc[0]}, 0);
    chk("rst_instr", {16'd0, dinstr[0]}, 0);

    deq_ready = 1; lat = 1;
    do_reset();
    cyc(14);
    chk("seq_addr0", {16'd0, qget(alog[0], 0)}, 32'h0000);
    chk("seq_addr1", {16'd0, qget(alog[0], 1)}, 32'h0002);
    chk("seq_addr2", {16'd0, qget(alog[0], 2)}, 32'h0004);
    chk("seq_pc0", {16'd0, qget(plog[0], 0)}, 32'h0002);
    chk("seq_pc1", {16'd0, qget(plog[0], 1)}, 32'h0004);
    chk("seq_pc2", {16'd0, qget(plog[0], 2)}, 32'h0006);

    deq_ready = 0;
    do_reset();
    cyc(20);
    chk("full_pushes", alog[0].size(), 4);
    @(negedge clk);
    chk("full_read", {31'd0, rd[0]}, 0);
    deq_ready = 1;
    cyc(1);
    deq_ready = 0;
    cyc(12);
    chk("pop_refill", alog[0].size(), 5);
    @(negedge clk);
    chk("refill_read", {31'd0, rd[0]}, 0);

    deq_ready = 1; lat = 1;
    do_reset();
    for (int i = 0; i < 40 && alog[0].size() < 3; i++) cyc(1);
    lat = 1000;
    chk("pend_wait", {31'd0, alog[0].size() >= 3}, 1);
    cyc(3);
    @(negedge clk);
    chk("pend_addr", {16'd0, addr[0]}, 32'h0006);
    chk("pend_read", {31'd0, rd[0]}, 1);
    redirect = 1; redirect_pc = 16'h3000;
    cyc(1);
    redirect = 0;
    @(negedge clk);
    chk("disc_addr", {16'd0, addr[0]}, 32'h0006);
    chk("disc_valid", {31'd0, dv[0]}, 0);
    lat = 1;
    cyc(10);
    chk("disc_drop", {16'd0, qget(alog[0], 3)}, 32'h0006);
    chk("disc_next", {16'd0, qget(alog[0], 4)}, 32'h3000);
    chk("disc_pc", {16'd0, qget(plog[0], 3)}, 32'h3002);

    deq_ready = 0; lat = 1;
    do_reset();
    cyc(20);
    @(negedge clk);
    chk("rr_full", {31'd0, dv[0]}, 1);
    deq_ready = 1; lat = 1000;
    cyc(1);
    deq_ready = 0;
    cyc(4);
    redirect = 1; redirect_pc = 16'h4000; deq_ready = 1; lat = 0;
    @(negedge clk);
    chk("rr_resp_read", {31'd0, rd[0]}, 1);
    cyc(1);
    redirect = 0; lat = 1000;
    n0 = plog[0].size();
    @(negedge clk);
    chk("rr_empty", {31'd0, dv[0]}, 0);
    chk("rr_addr", {16'd0, addr[0]}, 32'h4000);
    lat = 1;
    cyc(8);
    chk("rr_pc", {16'd0, qget(plog[0], n0)}, 32'h4002);

    deq_ready = 1; lat = 1; reset = 1;
    cyc(2);
    reset = 0; redirect = 1; redirect_pc = 16'h000E;
    clear_logs();
    cyc(1);
    redirect = 0;
    cyc(12);
    chk("f2_addr0", {16'd0, qget(alog[1], 0)}, 32'h000E);
    chk("f2_addr1", {16'd0, qget(alog[1], 1)}, 32'h0010);
    chk("f2_pc0", {16'd0, qget(plog[1], 0)}, 32'h0010);
    chk("f2_pc1", {16'd0, qget(plog[1], 1)}, 32'h0012);
    chk("f2_pc2", {16'd0, qget(plog[1], 2)}, 32'h0014);

    deq_ready = 0; lat = 1;
    do_reset();
    cyc(5);
    lat = 1000;
    cyc(2);
    @(negedge clk);
    chk("mid_read", {31'd0, rd[0]}, 1);
    chk("mid_valid", {31'd0, dv[0]}, 1);
    reset = 1;
    cyc(1);
    @(negedge clk);
    chk("mid_rst_read", {31'd0, rd[0]}, 0);
    chk("mid_rst_valid", {31'd0, dv[0]}, 0);
    chk("mid_rst_addr", {16'd0, addr[0]}, 32'h0000);
    chk("mid_rst_pc", {16'd0, dpc[0]}, 0);
    reset = 0; lat = 1;
    clear_logs();
    cyc(6);
    chk("mid_restart", {16'd0, qget(alog[0], 0)}, 32'h0000);

    for (int c = 0; c < 4000; c++) begin
      deq_ready = ($urandom % 10) < 6;
      redirect = ($urandom % 25) == 0;
      redirect_pc = 16'($urandom);
      if ($urandom % 2) redirect_pc[15:4] = ($urandom % 2) ? 12'hFFF : 12'h000;
      lat = $urandom % 4;
      reset = ($urandom % 400) == 0;
      cyc(1);
    end
    reset = 0; redirect = 0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
